uart_word_tx: RTL and testbench
===============================

UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 Parameter: WORD_BYTES, default 4, number of bytes per word to serialise; legal range 1..16.
REQ-002 Port: clk  input  1  single system clock, all logic on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: word_valid  input  1  upstream word available.
REQ-005 Port: word_data  input  8*WORD_BYTES  word to send, sampled on accept.
REQ-006 Port: word_ready  output  1  block can accept a word this cycle.
REQ-007 Port: tx_start  output  1  one-cycle start request to the UART byte transmitter.
REQ-008 Port: tx_data  output  8  byte presented to the UART byte transmitter.
REQ-009 Port: tx_done_tick  input  1  one-cycle pulse from the UART byte transmitter after the stop bit.
REQ-010 Port: busy  output  1  high from word accept until the cycle done_tick is asserted.
REQ-011 Port: done_tick  output  1  one-cycle pulse when the whole word, and checksum if enabled, has been sent.

Function
REQ-012 The FSM SHALL have states IDLE, SEND, WAIT and FINISH, encoded in 2 bits.
REQ-013 word_ready SHALL be 1 only in IDLE; accept occurs when word_valid and word_ready are both 1 on a clock edge.
REQ-014 On accept, the block SHALL copy word_data into an internal shift buffer, clear the byte index and any checksum accumulator, and go to SEND.
REQ-015 In SEND, the block SHALL assert tx_start for exactly one cycle, with tx_data equal to the current byte, then go to WAIT.
REQ-016 Bytes SHALL be sent MSB first: byte 0 is word_data[8*WORD_BYTES-1 -: 8].
REQ-017 tx_data SHALL stay stable from the SEND cycle until the tx_done_tick for that byte.
REQ-018 In WAIT, on tx_done_tick the block SHALL shift the buffer left by 8 bits and increment the byte index.
REQ-019 After that tx_done_tick, the FSM SHALL return to SEND if bytes remain, otherwise go to FINISH.
REQ-020 Latency from a tx_done_tick to the next tx_start SHALL be exactly 1 cycle.
REQ-021 Latency from accept to the first tx_start SHALL be exactly 1 cycle.
REQ-022 In FINISH, the block SHALL assert done_tick for one cycle and go to IDLE, so word_ready is 1 on the following cycle.
REQ-023 tx_done_tick outside WAIT SHALL be ignored.
REQ-024 word_valid while busy SHALL be ignored; upstream holds the word until accepted.
REQ-025 The byte index SHALL be sized to $clog2(WORD_BYTES+1) and SHALL NOT wrap within a word.
REQ-026 With WORD_BYTES=1, the FSM SHALL go directly from WAIT to FINISH after the first tx_done_tick.
REQ-027 busy SHALL equal (state != IDLE).

Reset
REQ-028 Asserting rst_n low SHALL, asynchronously, force state IDLE, tx_start=0, tx_data=8'h00, done_tick=0, buffer=0, index=0, checksum=0.
REQ-029 Reset mid-word SHALL abandon the word with no done_tick; a later tx_done_tick SHALL be ignored.
REQ-030 After rst_n deasserts, word_ready SHALL be 1 on the first clock edge.

Configuration
REQ-031 Macro UART_WORD_TX_CHECKSUM_EN, when defined, SHALL make the block send one extra byte after the last data byte: the XOR of all WORD_BYTES data bytes, using the same SEND/WAIT handshake.
REQ-032 Without UART_WORD_TX_CHECKSUM_EN, exactly WORD_BYTES bytes SHALL be sent and no checksum logic SHALL be synthesised.

Verification
REQ-033 Scenario: WORD_BYTES=4, word 0xDEADBEEF accepted, with tx_done_tick returned 20 cycles after each tx_start -> tx_start pulses carry DE, AD, BE, EF; done_tick fires 1 cycle after the 4th tx_done_tick.
REQ-034 Scenario: same stimulus with UART_WORD_TX_CHECKSUM_EN defined -> 5th byte is 0x22; done_tick fires after the 5th tx_done_tick.
REQ-035 Scenario: word_valid held high continuously with words 0x01020304 then 0xA0B0C0D0 -> the second accept occurs the cycle after done_tick; byte sequence is 01 02 03 04 A0 B0 C0 D0 with no gaps beyond REQ-020.
REQ-036 Scenario: rst_n pulsed low after the 2nd byte of 0x11223344 -> tx_start and done_tick stay 0, word_ready returns 1, a stray tx_done_tick is ignored, and the next word 0x55667788 starts at byte 55.
REQ-037 Scenario: tx_done_tick pulsed in IDLE and in the SEND cycle -> no state change, no extra bytes sent.
REQ-038 Scenario: WORD_BYTES=1, word 0x5A -> one tx_start with tx_data 5A; done_tick 1 cycle after tx_done_tick.

Source files
------------

// File: rtl/uart_word_tx.sv
// uart_word_tx: serialises a WORD_BYTES-wide word MSB-first through a UART byte transmitter.
// Latency: first tx_start 1 cycle after accept, next tx_start 1 cycle after each tx_done_tick, done_tick 1 cycle after the last.
// Backpressure: word_ready only in IDLE; word_valid is ignored while busy and upstream holds the word.
// Optional: define UART_WORD_TX_CHECKSUM_EN to append one XOR-of-all-data-bytes checksum byte.
module uart_word_tx #(
  parameter int WORD_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    word_valid,
  input  logic [8*WORD_BYTES-1:0] word_data,
  output logic                    word_ready,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  input  logic                    tx_done_tick,
  output logic                    busy,
  output logic                    done_tick
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int IW = $clog2(WORD_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t        state;
  logic [W-1:0]  shift_buf;
  logic [IW-1:0] idx;
  logic [W-1:0]  buf_shift;
  logic [IW-1:0] idx_inc;
  logic          last_data;

`ifdef UART_WORD_TX_CHECKSUM_EN
  // Running XOR of data bytes already handed to the transmitter.
  logic [7:0] csum;
  // Set once the checksum byte itself is in flight.
  logic       csum_sent;
`endif

  assign word_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  // Next buffer contents and byte count after the current byte completes.
  always_comb begin
    buf_shift = shift_buf << 8;
    idx_inc   = idx + IW'(1);
    last_data = (idx_inc == IW'(WORD_BYTES));
  end

  // Word FSM; tx_start/tx_data/done_tick are registered so the transmitter sees clean levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      done_tick <= 1'b0;
      shift_buf <= '0;
      idx       <= '0;
`ifdef UART_WORD_TX_CHECKSUM_EN
      csum      <= 8'h00;
      csum_sent <= 1'b0;
`endif
    end else begin
      tx_start  <= 1'b0;
      done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (word_valid) begin
            // The first byte is loaded here so tx_start lands in the SEND cycle.
            shift_buf <= word_data;
            idx       <= '0;
            tx_data   <= word_data[W-1 -: 8];
            tx_start  <= 1'b1;
            state     <= SEND;
`ifdef UART_WORD_TX_CHECKSUM_EN
            csum      <= 8'h00;
            csum_sent <= 1'b0;
`endif
          end
        end
        SEND: begin
          state <= WAIT;
        end
        WAIT: begin
          if (tx_done_tick) begin
`ifdef UART_WORD_TX_CHECKSUM_EN
            if (csum_sent) begin
              state     <= FINISH;
              done_tick <= 1'b1;
            end else begin
              shift_buf <= buf_shift;
              idx       <= idx_inc;
              csum      <= csum ^ tx_data;
              tx_start  <= 1'b1;
              state     <= SEND;
              if (last_data) begin
                tx_data   <= csum ^ tx_data;
                csum_sent <= 1'b1;
              end else begin
                tx_data <= buf_shift[W-1 -: 8];
              end
            end
`else
            shift_buf <= buf_shift;
            idx       <= idx_inc;
            if (last_data) begin
              state     <= FINISH;
              done_tick <= 1'b1;
            end else begin
              tx_data  <= buf_shift[W-1 -: 8];
              tx_start <= 1'b1;
              state    <= SEND;
            end
`endif
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: a 4-byte and a 1-byte instance driven by directed words.
// Bytes and done pulses expected are queued at issue time; monitors pop them as the DUT presents tx_start/done_tick.
// Byte transmitters are emulated by fixed-delay responders that return tx_done_tick.
module tb_uart_word_tx;

`ifdef UART_WORD_TX_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int NB_A = 4 + CS;
  localparam int NB_B = 1 + CS;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // DUT A: WORD_BYTES = 4
  logic        a_word_valid, a_word_ready, a_tx_start, a_tx_done_tick, a_busy, a_done_tick;
  logic [31:0] a_word_data;
  logic [7:0]  a_tx_data;
  logic        a_resp, a_stray;
  assign a_tx_done_tick = a_resp | a_stray;

  // DUT B: WORD_BYTES = 1
  logic        b_word_valid, b_word_ready, b_tx_start, b_tx_done_tick, b_busy, b_done_tick;
  logic [7:0]  b_word_data;
  logic [7:0]  b_tx_data;
  logic        b_resp;
  assign b_tx_done_tick = b_resp;

  uart_word_tx #(.WORD_BYTES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .word_valid(a_word_valid), .word_data(a_word_data),
    .word_ready(a_word_ready), .tx_start(a_tx_start), .tx_data(a_tx_data),
    .tx_done_tick(a_tx_done_tick), .busy(a_busy), .done_tick(a_done_tick)
  );

  uart_word_tx #(.WORD_BYTES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .word_valid(b_word_valid), .word_data(b_word_data),
    .word_ready(b_word_ready), .tx_start(b_tx_start), .tx_data(b_tx_data),
    .tx_done_tick(b_tx_done_tick), .busy(b_busy), .done_tick(b_done_tick)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard state
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int done_exp_a = 0, done_exp_b = 0;
  int starts_a = 0, starts_b = 0;
  logic [7:0] last_a = 8'h00, last_b = 8'h00;
  logic prev_tick_a = 1'b0, prev_acc_a = 1'b0, prev_tick_b = 1'b0, prev_acc_b = 1'b0;
  int done_cyc_a = -10, acc_cyc_a = -10;

  // Monitor A
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_tx_start) begin
        starts_a++;
        check("a_start_latency", int'(prev_acc_a | prev_tick_a), 1);
        check("a_start_expected", int'(exp_a.size() != 0), 1);
        if (exp_a.size() != 0) check("a_byte", int'(a_tx_data), int'(exp_a.pop_front()));
        last_a = a_tx_data;
      end
      if (a_tx_done_tick && a_busy) check("a_data_stable", int'(a_tx_data), int'(last_a));
      if (a_done_tick) begin
        check("a_done_after_tick", int'(prev_tick_a), 1);
        check("a_done_expected", int'(done_exp_a > 0), 1);
        if (done_exp_a > 0) done_exp_a--;
        done_cyc_a = cyc;
      end
      check("a_busy", int'(a_busy), int'(!a_word_ready));
      prev_acc_a  = a_word_valid & a_word_ready;
      prev_tick_a = a_tx_done_tick;
      if (prev_acc_a) acc_cyc_a = cyc;
    end else begin
      prev_acc_a  = 1'b0;
      prev_tick_a = 1'b0;
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (rst_n) begin
      if (b_tx_start) begin
        starts_b++;
        check("b_start_latency", int'(prev_acc_b | prev_tick_b), 1);
        check("b_start_expected", int'(exp_b.size() != 0), 1);
        if (exp_b.size() != 0) check("b_byte", int'(b_tx_data), int'(exp_b.pop_front()));
        last_b = b_tx_data;
      end
      if (b_tx_done_tick && b_busy) check("b_data_stable", int'(b_tx_data), int'(last_b));
      if (b_done_tick) begin
        check("b_done_after_tick", int'(prev_tick_b), 1);
        check("b_done_expected", int'(done_exp_b > 0), 1);
        if (done_exp_b > 0) done_exp_b--;
      end
      prev_acc_b  = b_word_valid & b_word_ready;
      prev_tick_b = b_tx_done_tick;
    end else begin
      prev_acc_b  = 1'b0;
      prev_tick_b = 1'b0;
    end
  end

  // Byte transmitter emulators: tx_done_tick a fixed number of cycles after each tx_start.
  int cnt_a = 0, cnt_b = 0;
  initial begin
    a_resp = 1'b0;
    b_resp = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      a_resp = 1'b0;
      b_resp = 1'b0;
      if (cnt_a > 0) begin
        cnt_a--;
        if (cnt_a == 0) a_resp = 1'b1;
      end
      if (cnt_b > 0) begin
        cnt_b--;
        if (cnt_b == 0) b_resp = 1'b1;
      end
      if (a_tx_start) cnt_a = 20;
      if (b_tx_start) cnt_b = 5;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word_a(input logic [31:0] w);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 3; i >= 0; i--) begin
      exp_a.push_back(w[8*i +: 8]);
      x = x ^ w[8*i +: 8];
    end
    if (CS != 0) exp_a.push_back(x);
    done_exp_a++;
  endtask

  task automatic wait_ready_a(input string name);
    int n;
    n = 0;
    while (!a_word_ready && n < 3000) begin
      tick();
      n++;
    end
    check(name, int'(a_word_ready), 1);
  endtask

  task automatic send_a(input logic [31:0] w);
    push_word_a(w);
    a_word_data  = w;
    a_word_valid = 1'b1;
    wait_ready_a("a_accept_timeout");
    tick();
    a_word_valid = 1'b0;
  endtask

  task automatic wait_done_a();
    int n;
    n = 0;
    while (done_exp_a != 0 && n < 3000) begin
      tick();
      n++;
    end
    check("a_done_timeout", done_exp_a, 0);
  endtask

  initial begin
    int base;
    int n;
    rst_n        = 1'b0;
    a_word_valid = 1'b0;
    a_word_data  = 32'h0;
    a_stray      = 1'b0;
    b_word_valid = 1'b0;
    b_word_data  = 8'h0;

    // Reset state
    repeat (3) tick();
    check("rst_a_ready", int'(a_word_ready), 1);
    check("rst_a_busy", int'(a_busy), 0);
    check("rst_a_tx_start", int'(a_tx_start), 0);
    check("rst_a_tx_data", int'(a_tx_data), 0);
    check("rst_a_done", int'(a_done_tick), 0);
    check("rst_b_ready", int'(b_word_ready), 1);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", int'(a_word_ready), 1);

    // 0xDEADBEEF: DE AD BE EF (+22 with checksum)
    base = starts_a;
    send_a(32'hDEADBEEF);
    wait_done_a();
    check("a_deadbeef_nbytes", starts_a - base, NB_A);

    // Stray tx_done_tick while idle
    base = starts_a;
    a_stray = 1'b1;
    tick();
    a_stray = 1'b0;
    repeat (5) tick();
    check("idle_tick_ready", int'(a_word_ready), 1);
    check("idle_tick_nostart", starts_a - base, 0);

    // Stray tx_done_tick in the SEND cycle
    send_a(32'hCAFEF00D);
    check("in_send_cycle", int'(a_tx_start), 1);
    a_stray = 1'b1;
    tick();
    a_stray = 1'b0;
    wait_done_a();
    check("send_tick_nbytes", starts_a - base, NB_A);

    // Back-to-back words with word_valid held high
    base = starts_a;
    push_word_a(32'h01020304);
    push_word_a(32'hA0B0C0D0);
    a_word_data  = 32'h01020304;
    a_word_valid = 1'b1;
    wait_ready_a("b2b_first_timeout");
    tick();
    a_word_data = 32'hA0B0C0D0;
    wait_ready_a("b2b_second_timeout");
    tick();
    a_word_valid = 1'b0;
    check("b2b_accept_after_done", acc_cyc_a, done_cyc_a + 1);
    wait_done_a();
    check("b2b_nbytes", starts_a - base, 2 * NB_A);

    // Reset after the 2nd byte of 0x11223344
    base = starts_a;
    exp_a.push_back(8'h11);
    exp_a.push_back(8'h22);
    a_word_data  = 32'h11223344;
    a_word_valid = 1'b1;
    wait_ready_a("mid_rst_accept_timeout");
    tick();
    a_word_valid = 1'b0;
    n = 0;
    while (starts_a - base < 2 && n < 3000) begin
      tick();
      n++;
    end
    check("mid_rst_two_bytes", starts_a - base, 2);
    rst_n = 1'b0;
    tick();
    check("mid_rst_tx_start", int'(a_tx_start), 0);
    check("mid_rst_ready", int'(a_word_ready), 1);
    tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check("after_rst_ready", int'(a_word_ready), 1);
    check("after_rst_nostart", starts_a - base, 2);
    check("after_rst_queue", exp_a.size(), 0);
    send_a(32'h55667788);
    wait_done_a();
    check("after_rst_nbytes", starts_a - base, 2 + NB_A);

    // WORD_BYTES = 1, word 0x5A (checksum of one byte is the byte itself)
    exp_b.push_back(8'h5A);
    if (CS != 0) exp_b.push_back(8'h5A);
    done_exp_b++;
    b_word_data  = 8'h5A;
    b_word_valid = 1'b1;
    n = 0;
    while (!b_word_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    b_word_valid = 1'b0;
    n = 0;
    while (done_exp_b != 0 && n < 200) begin
      tick();
      n++;
    end
    check("b_done_timeout", done_exp_b, 0);
    check("b_nbytes", starts_b, NB_B);

    tick();
    check("a_queue_empty", exp_a.size(), 0);
    check("b_queue_empty", exp_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
